// File: rtl/transmit_pkg.sv
// Shared UART framing definitions used by both the transmit and receive sides.
// Both ends build and check frames from the same constants and parity rule.
package transmit_pkg;

    localparam int FRAME_BITS = 11;

    // 100 MHz clock / 9600 baud = 10416.7 clocks per bit; one bit time is k+1 clocks.
    localparam int unsigned K_9600 = 10415;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } parity_sense_e;

    // Returns {b10, b9, d[6:0], start}. Unused b9/b10 positions become extra stop bits.
    function automatic logic [9:0] frame_body(input logic [7:0]    d,
                                              input logic          eight,
                                              input logic          parity_en,
                                              input parity_sense_e sense);
        logic b9;
        logic b10;
        b9  = 1'b1;
        b10 = 1'b1;
        if (eight) begin
            b9 = d[7];
            if (parity_en) b10 = (^d) ^ sense;
        end else if (parity_en) begin
            b9 = (^d[6:0]) ^ sense;
        end
        return {b10, b9, d[6:0], 1'b0};
    endfunction

endpackage

// File: rtl/transmit_bit_time_counter.sv
// Bit-time divider: btu pulses for one clock every k+1 enabled clocks.
// Holding enable low keeps the count at zero so the next bit time starts clean.
module bit_time_counter #(
    parameter int KW = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [KW-1:0] k,
    output logic          btu
);

    logic [KW-1:0] cnt_q;
    logic [KW-1:0] cnt_d;

    always_comb begin
        btu   = enable && (cnt_q == k);
        cnt_d = cnt_q + KW'(1);
        if (!enable || btu) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/transmit.sv
// UART transmitter: latches a byte on load, then shifts start/data/parity/stop
// bits out LSB first on tx, padded to FRAME_BITS bit times.
module transmit #(
    parameter int FRAME_BITS = transmit_pkg::FRAME_BITS,
    parameter int KW         = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [7:0]    data,
    input  logic          eight,
    input  logic          parity_en,
    input  logic          ohel,
    input  logic [KW-1:0] k,
    output logic          tx,
    output logic          TXRDY,
    output logic          done
);

    import transmit_pkg::*;

    localparam int CW = $clog2(FRAME_BITS + 1);

    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  busy_q, busy_d;
    logic                  start_q, start_d;
    logic                  txrdy_q, txrdy_d;
    logic                  done_q, done_d;
    logic [7:0]            data_q, data_d;
    logic                  eight_q, eight_d;
    logic                  parity_en_q, parity_en_d;
    parity_sense_e         sense_q, sense_d;
    logic [KW-1:0]         k_q, k_d;

    logic btu;
    logic count_en;
    logic accept;
    logic last_bit;

    // Handshake: load is a request, TXRDY the ready; a transfer happens only on a
    // clock edge where both are 1. load while TXRDY=0 is dropped, not queued.
    assign accept   = load && txrdy_q;
    assign last_bit = (bit_cnt_q == CW'(FRAME_BITS - 1));
    assign count_en = busy_q && !start_q;

    bit_time_counter #(.KW(KW)) u_bit_time_counter (
        .clk    (clk),
        .rst    (rst),
        .enable (count_en),
        .k      (k_q),
        .btu    (btu)
    );

    always_comb begin
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        busy_d      = busy_q;
        start_d     = start_q;
        txrdy_d     = txrdy_q;
        data_d      = data_q;
        eight_d     = eight_q;
        parity_en_d = parity_en_q;
        sense_d     = sense_q;
        k_d         = k_q;
        done_d      = 1'b0;

        if (accept) begin
            data_d      = data;
            eight_d     = eight;
            parity_en_d = parity_en;
            sense_d     = parity_sense_e'(ohel);
            k_d         = k;
            txrdy_d     = 1'b0;
            busy_d      = 1'b1;
            start_d     = 1'b1;
        end

        // The frame is built one cycle after accept, from the latched controls only.
        if (start_q) begin
            sr_d      = {{(FRAME_BITS - 10){1'b1}},
                         frame_body(data_q, eight_q, parity_en_q, sense_q)};
            bit_cnt_d = '0;
            start_d   = 1'b0;
        end else if (busy_q && btu) begin
            sr_d      = {1'b1, sr_q[FRAME_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + CW'(1);
            if (last_bit) begin
                bit_cnt_d = '0;
                busy_d    = 1'b0;
                txrdy_d   = 1'b1;
                done_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q        <= '1;
            bit_cnt_q   <= '0;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
            txrdy_q     <= 1'b1;
            done_q      <= 1'b0;
            data_q      <= '0;
            eight_q     <= 1'b0;
            parity_en_q <= 1'b0;
            sense_q     <= PAR_EVEN;
            k_q         <= '0;
        end else begin
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            busy_q      <= busy_d;
            start_q     <= start_d;
            txrdy_q     <= txrdy_d;
            done_q      <= done_d;
            data_q      <= data_d;
            eight_q     <= eight_d;
            parity_en_q <= parity_en_d;
            sense_q     <= sense_d;
            k_q         <= k_d;
        end
    end

    assign tx    = sr_q[0];
    assign TXRDY = txrdy_q;
    assign done  = done_q;

endmodule

// File: doc/transmit.md
Name: transmit

Overview:
- UART transmitter; the TX-side counterpart of the existing `receive` block in FULL_UART.
- Accepts a byte from the processor-side write strobe and serialises it LSB first on `tx`.
- Frame is start bit, 7 or 8 data bits, optional even/odd parity, then stop bit(s), always padded to 11 bit times.
- Uses the same runtime baud count `k` and the same format controls as `receive`, so both ends agree on framing.

Parameters:
- FRAME_BITS, 11, bit times per frame including start and stop/padding.
- KW, 19, width of baud count input `k`.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, asynchronous, active-low.
- load  in  1  write strobe; one-cycle pulse requests transmission of `data`.
- data  in  8  byte to send; sampled only on an accepted load.
- eight  in  1  1 = 8 data bits, 0 = 7 data bits.
- parity_en  in  1  1 = parity bit present.
- ohel  in  1  parity sense: 1 = odd, 0 = even.
- k  in  KW  baud divisor; one bit time = k+1 clocks.
- tx  out  1  serial line; idles high.
- TXRDY  out  1  1 = ready to accept a load.
- done  out  1  one-cycle pulse when the last bit time of a frame ends.

Behaviour:
- Reset (rst=0, asynchronous):
  - tx=1, TXRDY=1, done=0.
  - Shift register all 1s; bit-time counter, bit counter and busy flag cleared.
  - Reset mid-frame aborts the frame immediately.
- Accept:
  - On an edge with load=1 and TXRDY=1: latch data, eight, parity_en, ohel and k; TXRDY<=0; busy<=1.
  - load while TXRDY=0 is ignored. No state changes and no latching.
- Start (cycle after accept):
  - Shift register loaded with {1, b10, b9, d[6:0], 0}.
  - tx = sr[0], so the start bit (0) appears on tx 1 clock after the accepting edge.
  - Bit-time counter = 0, bit counter = 0.
- Bit-time counter:
  - While busy, increments each clock.
  - When count == k_latched: btu=1 for that cycle and the counter returns to 0.
  - Each bit therefore lasts k+1 clocks; k=0 gives 1 clock per bit.
- On btu:
  - sr shifts right, filling a 1 at the MSB.
  - Bit counter increments.
- Frame end:
  - When the bit counter reaches FRAME_BITS (the 11th btu): busy<=0 and done=1 for exactly 1 cycle.
  - TXRDY<=1 on the same edge; tx is 1 (idle).
  - Total frame = 11*(k+1) clocks from start-bit onset.
- b9/b10 encoding, with P = (^bits) XOR ohel:
  - eight=0, parity_en=0: b9=1, b10=1.
  - eight=0, parity_en=1: b9 = P over d[6:0], b10=1.
  - eight=1, parity_en=0: b9=d[7], b10=1.
  - eight=1, parity_en=1: b9=d[7], b10 = P over d[7:0].
  - Unused positions are extra stop bits (1).
- Control changes:
  - Changes to eight, parity_en, ohel or k mid-frame have no effect on the frame in progress.
  - They apply only at the next accept.
- Back-to-back: a load on the same cycle TXRDY rises is accepted on the next edge. There is no idle gap beyond one accept cycle plus the start cycle.
- Signal cleanliness:
  - tx is a register output; no glitches.
  - done and TXRDY are registered.

Decomposition:
- Shared package/header:
  - FRAME_BITS = 11.
  - Parity-sense encoding (ODD=1, EVEN=0).
  - Default baud constant, e.g. K_9600 for a 100 MHz clock.
  - Shared by `receive` and `transmit`.
- Sub-module `bit_time_counter`:
  - Inputs: clk, rst, enable, k.
  - Output: btu.
  - Reusable by `receive`, where it is used at a half-bit preload for start-bit centring.
- Remainder (format/parity encode, shift register, bit counter, TXRDY logic) stays in `transmit`.

Test Plan:
- rst=0, load, eight=1, parity_en=1, ohel=0, k=108, data=0xAE -> tx sequence 0,0,1,1,1,0,1,0,1,1(parity),1, each level held 109 clocks; done pulses once at 1199 clocks after start-bit onset; TXRDY=1 after done.
- eight=0, parity_en=0, data=0x41, k=3 -> tx 0,1,0,0,0,0,0,1,1,1,1, 4 clocks per bit; data[7] ignored.
- eight=0, parity_en=1, ohel=1, data=0x03 -> parity bit (b9) = 1, b10 = 1; repeat with ohel=0 -> b9 = 0.
- Second load while TXRDY=0 with data=0xFF during a 0x00 frame -> frame unchanged (all data bits 0); no second frame; TXRDY stays 0 until done.
- Assert rst low mid-frame (during data bit 4) -> tx=1 and TXRDY=1 asynchronously; no done pulse; a subsequent load sends a clean full frame.
- k=0, data=0x55, eight=1, parity_en=0 -> 1 clock per bit; frame = 11 clocks; back-to-back load on the TXRDY-rise cycle gives next start bit exactly 2 clocks after done.
